// File: rtl/fpu_stim_gen.sv
// fpu_stim_gen: issues directed then LFSR operand vectors to an FPU and tallies results, errors and timeouts.
module fpu_stim_gen #(
    parameter int unsigned NUM_VEC = 256,
    parameter int unsigned TIMEOUT = 15,
    parameter logic [31:0] SEED_A  = 32'hACE1_2345,
    parameter logic [31:0] SEED_B  = 32'h1357_9BDF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        run,
    input  logic        done_in,
    input  logic [31:0] Y,
    input  logic        Error,
    input  logic        Overflow,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [1:0]  Sel,
    output logic [1:0]  round,
    output logic        start,
    output logic        busy,
    output logic        finished,
    output logic [15:0] vec_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] to_cnt,
    output logic [31:0] last_y
);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, CAPTURE = 3'd3, DONE = 3'd4;
    localparam logic [31:0] MASK = 32'h8020_0003;
    // an all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [31:0] RA = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
    localparam logic [31:0] RB = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
    localparam logic [15:0] NV = NUM_VEC[15:0];
    localparam logic [16:0] TO = TIMEOUT[16:0];

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? MASK : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [63:0] vec_ops(input logic [15:0] idx, input logic [31:0] la, input logic [31:0] lb);
        return (idx == 16'd0) ? {32'h0000_0000, 32'h3F80_0000} :
               (idx == 16'd1) ? {32'h7F80_0000, 32'h7F80_0000} :
               (idx == 16'd2) ? {32'h7FC0_0000, 32'h3F80_0000} :
               (idx == 16'd3) ? {32'h7F7F_FFFF, 32'h7F7F_FFFF} : {la, lb};
    endfunction

    logic [2:0]  state, nxt;
    logic [15:0] wait_cnt, vec_inc;
    logic [31:0] lfsr_a, lfsr_b, step_a, step_b;
    logic        timed_out;

    assign vec_inc   = sat_inc(vec_cnt);
    assign step_a    = lfsr_step(lfsr_a);
    assign step_b    = lfsr_step(lfsr_b);
    assign timed_out = ({1'b0, wait_cnt} + 17'd1) >= TO;
    assign Sel       = vec_cnt[1:0];
    assign round     = vec_cnt[3:2];

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = run ? ISSUE : IDLE;
            ISSUE:   nxt = run ? WAIT : IDLE;
            WAIT:    nxt = !run ? IDLE : (done_in || timed_out) ? CAPTURE : WAIT;
            CAPTURE: nxt = !run ? IDLE : (vec_inc == NV) ? DONE : ISSUE;
            DONE:    nxt = run ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            A        <= '0;
            B        <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            to_cnt   <= '0;
            last_y   <= '0;
            wait_cnt <= '0;
            lfsr_a   <= RA;
            lfsr_b   <= RB;
        end else begin
            state    <= nxt;
            start    <= nxt == ISSUE;
            busy     <= nxt inside {ISSUE, WAIT, CAPTURE};
            finished <= nxt == DONE;
            case (state)
                IDLE: if (run) begin
                    vec_cnt <= '0;
                    err_cnt <= '0;
                    to_cnt  <= '0;
                    last_y  <= '0;
                    lfsr_a  <= RA;
                    lfsr_b  <= RB;
                    {A, B}  <= vec_ops(16'd0, RA, RB);
                end
                ISSUE: wait_cnt <= '0;
                WAIT: if (run && !done_in) begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (timed_out) to_cnt <= sat_inc(to_cnt);
                end
                CAPTURE: begin
                    last_y  <= Y;
                    vec_cnt <= vec_inc;
                    lfsr_a  <= step_a;
                    lfsr_b  <= step_b;
                    if (Error || Overflow) err_cnt <= sat_inc(err_cnt);
                    // operands for the next vector are ready by its ISSUE cycle
                    if (nxt == ISSUE) {A, B} <= vec_ops(vec_inc, step_a, step_b);
                end
                default: ;
            endcase
        end
    end
endmodule
